// File: rtl/mem_port_pkg.sv
// Shared types and constants for the memory-port scheduler.
// Provides the FSM state enum, requester enum, iord_sel mux codes,
// exception codes and the grant payload struct.
package mem_port_pkg;

    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_FETCH = 2'd1,
        REQ_DATA  = 2'd2,
        REQ_EXC   = 2'd3
    } req_t;

    // Memory-address mux select codes
    localparam logic [SEL_W-1:0] SEL_PC     = 3'b000;
    localparam logic [SEL_W-1:0] SEL_ALUOUT = 3'b001;
    localparam logic [SEL_W-1:0] SEL_V253   = 3'b010;
    localparam logic [SEL_W-1:0] SEL_V254   = 3'b011;
    localparam logic [SEL_W-1:0] SEL_V255   = 3'b100;
    localparam logic [SEL_W-1:0] SEL_IN5    = 3'b101;
    localparam logic [SEL_W-1:0] SEL_IN6    = 3'b110;

    // Exception type codes
    localparam logic [1:0] EXC_NONE   = 2'b00;
    localparam logic [1:0] EXC_OPCODE = 2'b01;
    localparam logic [1:0] EXC_OVF    = 2'b10;
    localparam logic [1:0] EXC_DIV0   = 2'b11;

    // What gets latched at grant time
    typedef struct packed {
        req_t             who;
        logic [SEL_W-1:0] sel;
        logic             we;
    } grant_t;

    // Exception code -> handler vector select
    function automatic logic [SEL_W-1:0] vec_sel(input logic [1:0] code);
        logic [SEL_W-1:0] s;
        case (code)
            EXC_OPCODE: s = SEL_V253;
            EXC_OVF:    s = SEL_V254;
            EXC_DIV0:   s = SEL_V255;
            default:    s = SEL_PC;
        endcase
        return s;
    endfunction

    // Data address source -> mux select; source 3 aliases ALUOut
    function automatic logic [SEL_W-1:0] data_sel(input logic [1:0] src);
        logic [SEL_W-1:0] s;
        case (src)
            2'd1:    s = SEL_IN5;
            2'd2:    s = SEL_IN6;
            default: s = SEL_ALUOUT;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter timing the memory wait phase.
// Ports: clk, reset (sync, active-low), load/load_val (load has priority),
//        dec (decrement, saturates at 0), cnt (registered count),
//        zero_c (combinational: count is zero).
module mem_lat_counter
    import mem_port_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero_c
);

    assign zero_c = (cnt == W'(0));

    // Count register; never wraps below zero
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= W'(0);
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !zero_c) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/mem_port_sched.sv
// Sequencer/arbiter for the single memory port of the multicycle CPU.
// Grants the port to exception-vector fetch (highest), then data/fetch
// round-robin, and sequences IDLE -> ADDR (MEM_LAT cycles) -> DONE.
// Ports:
//   clk, reset (sync, active-low)
//   fetch_req, data_req, data_we, data_src[1:0], exc_req, exc_code[1:0]
//   iord_sel[2:0]  memory-address mux select
//   mem_wr, mdr_wr, epc_wr, pc_exc_wr  strobes
//   fetch_ack, data_ack, exc_ack       one-cycle completion pulses
//   busy           high whenever the sequencer is not idle
// All outputs are registered and line up with the state they belong to.
module mem_port_sched
    import mem_port_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_req,
    input  logic             data_req,
    input  logic             data_we,
    input  logic [1:0]       data_src,
    input  logic             exc_req,
    input  logic [1:0]       exc_code,
    output logic [SEL_W-1:0] iord_sel,
    output logic             mem_wr,
    output logic             mdr_wr,
    output logic             epc_wr,
    output logic             pc_exc_wr,
    output logic             fetch_ack,
    output logic             data_ack,
    output logic             exc_ack,
    output logic             busy
);

    state_t           state, state_nxt;
    grant_t           gnt, gnt_nxt;
    logic             last_data, last_data_nxt;

    logic             cnt_load, cnt_dec;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             lat_last;

    logic [SEL_W-1:0] sel_nxt;
    logic             mem_wr_nxt, mdr_wr_nxt, epc_wr_nxt, pc_exc_wr_nxt;
    logic             fetch_ack_nxt, data_ack_nxt, exc_ack_nxt, busy_nxt;

    logic             exc_valid;
    logic             pick_data;

    assign exc_valid = exc_req && (exc_code != EXC_NONE);
    // Data wins when alone, or when both pend and fetch had the last turn
    assign pick_data = data_req && (!fetch_req || !last_data);
    // Count reaches zero on this edge; the zero guard covers a zero load
    assign lat_last  = (cnt == CNT_W'(1)) || cnt_zero;

    mem_lat_counter #(
        .W (CNT_W)
    ) u_lat (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (CNT_W'(MEM_LAT)),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero_c   (cnt_zero)
    );

    // State, grant and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            gnt       <= '{who: REQ_NONE, sel: SEL_PC, we: 1'b0};
            last_data <= 1'b0;
            iord_sel  <= SEL_PC;
            mem_wr    <= 1'b0;
            mdr_wr    <= 1'b0;
            epc_wr    <= 1'b0;
            pc_exc_wr <= 1'b0;
            fetch_ack <= 1'b0;
            data_ack  <= 1'b0;
            exc_ack   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            last_data <= last_data_nxt;
            iord_sel  <= sel_nxt;
            mem_wr    <= mem_wr_nxt;
            mdr_wr    <= mdr_wr_nxt;
            epc_wr    <= epc_wr_nxt;
            pc_exc_wr <= pc_exc_wr_nxt;
            fetch_ack <= fetch_ack_nxt;
            data_ack  <= data_ack_nxt;
            exc_ack   <= exc_ack_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next state, grant decision and next-cycle outputs
    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt;
        last_data_nxt = last_data;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;
        sel_nxt       = SEL_PC;
        mem_wr_nxt    = 1'b0;
        mdr_wr_nxt    = 1'b0;
        epc_wr_nxt    = 1'b0;
        pc_exc_wr_nxt = 1'b0;
        fetch_ack_nxt = 1'b0;
        data_ack_nxt  = 1'b0;
        exc_ack_nxt   = 1'b0;
        busy_nxt      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (exc_valid) begin
                    gnt_nxt   = '{who: REQ_EXC, sel: vec_sel(exc_code), we: 1'b0};
                    state_nxt = ST_ADDR;
                end else if (pick_data) begin
                    gnt_nxt       = '{who: REQ_DATA, sel: data_sel(data_src), we: data_we};
                    last_data_nxt = 1'b1;
                    state_nxt     = ST_ADDR;
                end else if (fetch_req) begin
                    gnt_nxt       = '{who: REQ_FETCH, sel: SEL_PC, we: 1'b0};
                    last_data_nxt = 1'b0;
                    state_nxt     = ST_ADDR;
                end

                // First ADDR cycle carries the one-shot write and EPC strobes
                if (state_nxt == ST_ADDR) begin
                    cnt_load   = 1'b1;
                    sel_nxt    = gnt_nxt.sel;
                    busy_nxt   = 1'b1;
                    mem_wr_nxt = (gnt_nxt.who == REQ_DATA) && gnt_nxt.we;
                    epc_wr_nxt = (gnt_nxt.who == REQ_EXC);
                end
            end

            ST_ADDR: begin
                cnt_dec  = 1'b1;
                sel_nxt  = gnt.sel;
                busy_nxt = 1'b1;
                if (lat_last) begin
                    state_nxt     = ST_DONE;
                    fetch_ack_nxt = (gnt.who == REQ_FETCH);
                    data_ack_nxt  = (gnt.who == REQ_DATA);
                    exc_ack_nxt   = (gnt.who == REQ_EXC);
                    mdr_wr_nxt    = !((gnt.who == REQ_DATA) && gnt.we);
                    pc_exc_wr_nxt = (gnt.who == REQ_EXC);
                end
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
